// File: rtl/target_lut_pkg.sv
// Shared constants and types for the branch-target pointer encoder.
//   DEPTH : number of runtime table entries
//   PTR_W : pointer width into the table
//   PC_W  : width of a full PC target
//   CNT_W : width of the live-entry count (must hold DEPTH itself)
package target_lut_pkg;

    localparam int DEPTH = 32;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int PC_W  = 10;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } enc_state_t;

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // True when a pointer addresses a live entry.
    function automatic logic ptr_live(input ptr_t addr, input cnt_t count);
        return {1'b0, addr} < count;
    endfunction

endpackage

// File: rtl/target_table.sv
// Runtime target table: DEPTH x PC_W registers.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (zeroes every entry)
//   we/waddr/wdata   : single synchronous write port
//   count            : live-entry count; reads at or beyond it return 0
//   rd_addr/rd_target: combinational fetch-side read, count-masked
//   cmp_addr/cmp_target: combinational raw read used by the encoder's scan
module target_table
    import target_lut_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic we,
    input  ptr_t waddr,
    input  pc_t  wdata,
    input  cnt_t count,
    input  ptr_t rd_addr,
    output pc_t  rd_target,
    input  ptr_t cmp_addr,
    output pc_t  cmp_target
);

    pc_t  entry_reg [DEPTH];
    logic [DEPTH-1:0] wsel;

    // One-hot write decode.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wsel[gi] = we && (waddr == ptr_t'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (srst) begin
                entry_reg[i] <= '0;
            end else if (wsel[i]) begin
                entry_reg[i] <= wdata;
            end
        end
    end

    // Stale entries above count survive a flush, so the fetch read must
    // mask them to behave like the fixed table's zero default.
    assign rd_target  = ptr_live(rd_addr, count) ? entry_reg[rd_addr] : '0;
    assign cmp_target = entry_reg[cmp_addr];

endmodule

// File: rtl/target_ptr_encoder.sv
// Branch-target pointer encoder. Accepts a full PC target, searches the
// runtime table linearly (one entry per cycle) and returns the pointer of a
// matching entry, or appends the target and returns its new pointer. When the
// table is full and the target is absent, out_err is raised with pointer 0.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   clear               : synchronous flush of the table (count -> 0)
//   in_valid/in_ready   : request handshake, in_target carries the PC
//   out_valid/out_ready : response handshake, out_ptr/out_hit/out_err payload
//   rd_addr/rd_target   : combinational fetch-side decode
//   count               : number of live entries (0..DEPTH)
module target_ptr_encoder
    import target_lut_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic in_valid,
    input  pc_t  in_target,
    output logic in_ready,
    output logic out_valid,
    output ptr_t out_ptr,
    output logic out_hit,
    output logic out_err,
    input  logic out_ready,
    input  ptr_t rd_addr,
    output pc_t  rd_target,
    output cnt_t count
);

    enc_state_t state_reg, state_next;
    cnt_t       idx_reg, idx_next;        // one extra bit so idx can reach DEPTH
    pc_t        target_reg, target_next;
    cnt_t       count_reg, count_next;
    ptr_t       out_ptr_reg, out_ptr_next;
    logic       out_hit_reg, out_hit_next;
    logic       out_err_reg, out_err_next;

    logic tbl_we;
    pc_t  cmp_target;

    target_table u_table (
        .clk        (Clk),
        .srst       (Reset),
        .we         (tbl_we),
        .waddr      (count_reg[PTR_W-1:0]),
        .wdata      (target_reg),
        .count      (count_reg),
        .rd_addr    (rd_addr),
        .rd_target  (rd_target),
        .cmp_addr   (idx_reg[PTR_W-1:0]),
        .cmp_target (cmp_target)
    );

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        target_next  = target_reg;
        count_next   = count_reg;
        out_ptr_next = out_ptr_reg;
        out_hit_next = out_hit_reg;
        out_err_next = out_err_reg;
        tbl_we       = 1'b0;

        if (clear) begin
            // Flush drops any in-flight request; entries are left in place
            // and hidden by count.
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        target_next = in_target;
                        idx_next    = '0;
                        state_next  = SCAN;
                    end
                end
                SCAN: begin
                    if (idx_reg < count_reg) begin
                        if (cmp_target == target_reg) begin
                            out_ptr_next = idx_reg[PTR_W-1:0];
                            out_hit_next = 1'b1;
                            out_err_next = 1'b0;
                            state_next   = RESP;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else if (count_reg < cnt_t'(DEPTH)) begin
                        // Not found: append at the tail.
                        tbl_we       = 1'b1;
                        out_ptr_next = count_reg[PTR_W-1:0];
                        out_hit_next = 1'b0;
                        out_err_next = 1'b0;
                        count_next   = count_reg + 1'b1;
                        state_next   = RESP;
                    end else begin
                        // Not found and no room: report, table untouched.
                        out_ptr_next = '0;
                        out_hit_next = 1'b0;
                        out_err_next = 1'b1;
                        state_next   = RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            target_reg  <= '0;
            count_reg   <= '0;
            out_ptr_reg <= '0;
            out_hit_reg <= 1'b0;
            out_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            target_reg  <= target_next;
            count_reg   <= count_next;
            out_ptr_reg <= out_ptr_next;
            out_hit_reg <= out_hit_next;
            out_err_reg <= out_err_next;
        end
    end

    // No bypass: a new request is only taken from IDLE, one cycle after the
    // response handshake completes.
    assign in_ready  = (state_reg == IDLE) && !clear && !Reset;
    assign out_valid = (state_reg == RESP);
    assign out_ptr   = out_ptr_reg;
    assign out_hit   = out_hit_reg;
    assign out_err   = out_err_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_target_ptr_encoder.sv
// Directed bench for target_ptr_encoder. A queue of stored targets models the
// table; each request's pointer, hit/err and latency are derived from a search
// of that queue, and a per-cycle monitor checks count and rd_target against it.
module tb_target_ptr_encoder;
    import target_lut_pkg::*;

    logic Clk = 1'b0;
    logic Reset, clear, in_valid, out_ready;
    pc_t  in_target;
    ptr_t rd_addr;
    logic in_ready, out_valid, out_hit, out_err;
    ptr_t out_ptr;
    pc_t  rd_target;
    cnt_t count;

    int errors = 0;
    int checks = 0;
    pc_t model_q[$];
    bit  mon_en = 1'b0;

    always #5 Clk = ~Clk;

    target_ptr_encoder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_target (in_target),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ptr   (out_ptr),
        .out_hit   (out_hit),
        .out_err   (out_err),
        .out_ready (out_ready),
        .rd_addr   (rd_addr),
        .rd_target (rd_target),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Per-cycle monitor of table state against the model.
    always @(negedge Clk) begin
        if (mon_en) begin
            logic [31:0] exp_rd;
            exp_rd = (int'(rd_addr) < model_q.size()) ? 32'(model_q[rd_addr]) : 32'd0;
            chk("mon_count", 32'(count), 32'(model_q.size()));
            chk("mon_rd_target", 32'(rd_target), exp_rd);
        end
    end

    // One request/response. lit_* >= 0 pin hand-computed expectations.
    task automatic send(input pc_t t, input int hold, input int lit_ptr,
                        input int lit_hit, input int lit_lat);
        int  k, lat, eptr;
        bit  ehit, eerr, ins;
        k = -1;
        foreach (model_q[i]) if (k < 0 && model_q[i] == t) k = i;
        if (k >= 0) begin
            lat = k + 1; eptr = k; ehit = 1; eerr = 0; ins = 0;
        end else if (model_q.size() < DEPTH) begin
            lat = model_q.size() + 1; eptr = model_q.size(); ehit = 0; eerr = 0; ins = 1;
        end else begin
            lat = DEPTH + 1; eptr = 0; ehit = 0; eerr = 1; ins = 0;
        end
        if (lit_lat >= 0) chk("lat_lit", lat, lit_lat);

        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_target = t;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < lat; c++) begin
            chk("out_valid_early", 32'(out_valid), 0);
            tick();
        end
        if (ins) model_q.push_back(t);
        chk("out_valid", 32'(out_valid), 1);
        chk("out_ptr", 32'(out_ptr), eptr);
        chk("out_hit", 32'(out_hit), 32'(ehit));
        chk("out_err", 32'(out_err), 32'(eerr));
        chk("in_ready_resp", 32'(in_ready), 0);
        if (lit_ptr >= 0) chk("out_ptr_lit", 32'(out_ptr), lit_ptr);
        if (lit_hit >= 0) chk("out_hit_lit", 32'(out_hit), lit_hit);

        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_target = t ^ 10'h155;
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_ptr", 32'(out_ptr), eptr);
            chk("hold_hit", 32'(out_hit), 32'(ehit));
            chk("hold_err", 32'(out_err), 32'(eerr));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_done", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
        $display("txn target=%03h ptr=%0d hit=%0d err=%0d lat=%0d hold=%0d count=%0d",
                 t, eptr, ehit, eerr, lat, hold, model_q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_target = '0; rd_addr = '0;

        // Reset state
        tick();
        mon_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_ptr", 32'(out_ptr), 0);
        chk("rst_out_hit", 32'(out_hit), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_count", 32'(count), 0);
        tick();
        Reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 1);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = ptr_t'(a);
            #1;
            chk("rst_rd_target", 32'(rd_target), 0);
            tick();
        end

        // First inserts
        send(10'h034, 0, 0, 0, 1);
        send(10'h03D, 0, 1, 0, 2);
        send(10'h040, 0, 2, 0, 3);
        chk("count_3", 32'(count), 3);
        rd_addr = 5'd1;
        #1;
        chk("rd_addr1", 32'(rd_target), 32'h03D);

        // Duplicate reuse
        send(10'h053, 0, 3, 0, 4);
        send(10'h053, 0, 3, 1, 4);
        chk("count_4", 32'(count), 4);

        // Back-pressure
        send(10'h034, 5, 0, 1, 1);

        // Fill to capacity; target 0 is an ordinary entry
        send(10'h000, 0, 4, 0, 5);
        for (int i = 0; i < 27; i++) send(pc_t'(10'h100 + i), 0, 5 + i, 0, -1);
        chk("count_full", 32'(count), 32);

        // Full and absent -> error
        send(10'h3FF, 0, 0, 0, 33);
        chk("err_full", 32'(out_err), 1);
        chk("count_after_err", 32'(count), 32);
        send(10'h03D, 0, 1, 1, 2);
        chk("err_cleared", 32'(out_err), 0);
        send(10'h000, 0, 4, 1, 5);

        // Clear during a long scan
        in_valid  = 1'b1;
        in_target = 10'h113;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("scan_valid_low", 32'(out_valid), 0);
            tick();
        end
        clear = 1'b1;
        #1;
        chk("clear_in_ready", 32'(in_ready), 0);
        tick();
        clear = 1'b0;
        model_q.delete();
        chk("clear_count", 32'(count), 0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = ptr_t'(a);
            #1;
            chk("clear_valid_low", 32'(out_valid), 0);
            chk("clear_rd_target", 32'(rd_target), 0);
            tick();
        end
        $display("txn clear mid-scan count=%0d", model_q.size());

        // Clear together with a request in IDLE: nothing accepted
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_target = 10'h2AA;
        #1;
        chk("clear_idle_in_ready", 32'(in_ready), 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("clear_idle_no_resp", 32'(out_valid), 0);
            tick();
        end
        chk("clear_idle_count", 32'(count), 0);
        $display("txn clear with in_valid ignored");

        send(10'h155, 0, 0, 0, 1);

        // Reset during a scan: no response, no write
        in_valid  = 1'b1;
        in_target = 10'h200;
        tick();
        in_valid = 1'b0;
        Reset    = 1'b1;
        tick();
        Reset = 1'b0;
        model_q.delete();
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_valid", 32'(out_valid), 0);
        tick();
        chk("rst_mid_valid2", 32'(out_valid), 0);
        $display("txn reset mid-scan count=%0d", model_q.size());

        send(10'h200, 0, 0, 0, 1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
